// File: rtl/pipe_int_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// pipe_int_pkg: shared FSM states, vector defaults, cause width
// rev 1.0
// ---------------------------------------------------------------
package pipe_int_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    HANDLER = 2'd2,
    RESTORE = 2'd3
  } int_state_e;

  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;

  function automatic int cause_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_int_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------
// pipe_int_ctrl_if: IRQ, pipeline-control and PC-redirect bundle
// rev 1.0
// ---------------------------------------------------------------
interface pipe_int_ctrl_if #(
  parameter int N_IRQ = 4
);
  import pipe_int_pkg::*;
  localparam int CW = cause_w(N_IRQ);

  logic [N_IRQ-1:0] irq_in;
  logic [N_IRQ-1:0] irq_mask;
  logic             glb_int_en;
  logic             pipe_stall;
  logic [31:0]      cur_pc;
  logic             eret;
  logic             INT_detected;
  logic             INT_restore;
  logic             pc_redirect;
  logic [31:0]      redirect_pc;
  logic [31:0]      epc;
  logic [CW-1:0]    int_cause;
  logic             int_active;
  logic [N_IRQ-1:0] irq_ack;
  logic             wdog_fire;

  modport master (
    input  irq_in, irq_mask, glb_int_en, pipe_stall, cur_pc, eret,
    output INT_detected, INT_restore, pc_redirect, redirect_pc, epc,
           int_cause, int_active, irq_ack, wdog_fire
  );

  modport slave (
    output irq_in, irq_mask, glb_int_en, pipe_stall, cur_pc, eret,
    input  INT_detected, INT_restore, pc_redirect, redirect_pc, epc,
           int_cause, int_active, irq_ack, wdog_fire
  );

endinterface
`default_nettype wire

// File: rtl/pipe_int_ctrl_prio_enc.sv
`default_nettype none
// ---------------------------------------------------------------
// irq_prio_enc: lowest-index-wins priority encoder
// rev 1.0
// ---------------------------------------------------------------
module irq_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  // Scanning downward lets the lowest set index overwrite last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_int_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------
// pipe_int_ctrl: pipeline interrupt sequencer (optional PIPE_INT_WDOG_EN)
// rev 1.0
// ---------------------------------------------------------------
module pipe_int_ctrl
  import pipe_int_pkg::*;
#(
  parameter int          N_IRQ       = 4,
  parameter logic [31:0] VEC_BASE    = VEC_BASE_DEF,
  parameter logic [31:0] VEC_STRIDE  = VEC_STRIDE_DEF,
  parameter int          WDOG_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  pipe_int_ctrl_if.master  bus
);

  localparam int CW = cause_w(N_IRQ);

  int_state_e       state;
  int_state_e       state_nxt;
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] ack_clr;
  logic             win_valid;
  logic [CW-1:0]    win_idx;
  logic             take;
  logic [31:0]      epc_q;
  logic [CW-1:0]    cause_q;
  logic             wd_expire;
  logic             wd_fire_q;
  logic             wd_fire_nxt;

  assign rise     = bus.irq_in & ~irq_q;
  assign eligible = pending & ~bus.irq_mask;

  irq_prio_enc #(
    .N (N_IRQ),
    .W (CW)
  ) u_prio (
    .req   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  assign take    = (state == IDLE) && bus.glb_int_en && win_valid && !bus.pipe_stall;
  assign ack_clr = take ? (N_IRQ'(1) << win_idx) : '0;

  // A fresh rise re-arms a bit even in the cycle it is being cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q   <= '0;
      pending <= '0;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      irq_q   <= bus.irq_in;
      pending <= (pending & ~ack_clr) | rise;
      if (take) begin
        epc_q   <= bus.cur_pc;
        cause_q <= win_idx;
      end
    end
  end

`ifdef PIPE_INT_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES) + 1;
  logic [WW-1:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == SAVE) begin
      wd_cnt <= '0;
    end else if (state == HANDLER) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_expire = (state == HANDLER) && (wd_cnt == WW'(WDOG_CYCLES - 1));
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wd_fire_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      wd_fire_q <= wd_fire_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wd_fire_nxt = 1'b0;
    case (state)
      IDLE:    if (take) state_nxt = SAVE;
      SAVE:    state_nxt = HANDLER;
      HANDLER: begin
        if (bus.eret) begin
          state_nxt = RESTORE;
        end else if (wd_expire) begin
          state_nxt   = RESTORE;
          wd_fire_nxt = 1'b1;
        end
      end
      RESTORE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.INT_detected = 1'b0;
    bus.INT_restore  = 1'b0;
    bus.pc_redirect  = 1'b0;
    bus.redirect_pc  = '0;
    bus.int_active   = 1'b0;
    bus.irq_ack      = '0;
    bus.wdog_fire    = 1'b0;
    case (state)
      SAVE: begin
        bus.INT_detected = 1'b1;
        bus.int_active   = 1'b1;
        bus.pc_redirect  = 1'b1;
        bus.redirect_pc  = VEC_BASE + 32'(cause_q) * VEC_STRIDE;
        bus.irq_ack      = N_IRQ'(1) << cause_q;
      end
      HANDLER: bus.int_active = 1'b1;
      RESTORE: begin
        bus.INT_restore = 1'b1;
        bus.pc_redirect = 1'b1;
        bus.redirect_pc = epc_q;
        bus.wdog_fire   = wd_fire_q;
      end
      default: ;
    endcase
  end

  assign bus.epc       = epc_q;
  assign bus.int_cause = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_int_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_pipe_int_ctrl: directed scenario bench for pipe_int_ctrl
// rev 1.0
// ---------------------------------------------------------------
module tb_pipe_int_ctrl;
  import pipe_int_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  pipe_int_ctrl_if #(.N_IRQ(4)) bus ();

  pipe_int_ctrl #(
    .N_IRQ       (4),
    .VEC_BASE    (32'h0000_0100),
    .VEC_STRIDE  (32'h0000_0010),
    .WDOG_CYCLES (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {INT_detected, INT_restore, pc_redirect, int_active, wdog_fire}
  localparam logic [4:0] F_IDLE = 5'b00000;
  localparam logic [4:0] F_SAVE = 5'b10110;
  localparam logic [4:0] F_HNDL = 5'b00010;
  localparam logic [4:0] F_REST = 5'b01100;
  localparam logic [4:0] F_WDOG = 5'b01101;

  function automatic logic [4:0] flags();
    return {bus.INT_detected, bus.INT_restore, bus.pc_redirect, bus.int_active, bus.wdog_fire};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.irq_in = '0; bus.irq_mask = '0; bus.glb_int_en = 1'b0;
    bus.pipe_stall = 1'b0; bus.cur_pc = '0; bus.eret = 1'b0;
    tick(); tick();
    total++;
    if ({flags(), bus.irq_ack, bus.epc, bus.int_cause, bus.redirect_pc} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: flags=%b ack=%b epc=%h cause=%0d rpc=%h (want all 0)",
               flags(), bus.irq_ack, bus.epc, bus.int_cause, bus.redirect_pc);
    end
    reset = 1'b0;
    bus.glb_int_en = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus.cur_pc = 32'h40;
    bus.irq_in = 4'b0100;
    tick();
    total++;
    if (flags() !== F_IDLE) begin
      bad++; $display("FAIL single_latency1: flags=%b want %b", flags(), F_IDLE);
    end
    tick();
    total++;
    if ({flags(), bus.irq_ack, bus.redirect_pc} !== {F_SAVE, 4'b0100, 32'h120}) begin
      bad++; $display("FAIL single_save: flags=%b ack=%b rpc=%h want %b 0100 00000120",
                      flags(), bus.irq_ack, bus.redirect_pc, F_SAVE);
    end
    total++;
    if ({bus.epc, bus.int_cause} !== {32'h40, 2'd2}) begin
      bad++; $display("FAIL single_epc_cause: epc=%h cause=%0d want 00000040 2", bus.epc, bus.int_cause);
    end
    tick();
    total++;
    if ({flags(), bus.irq_ack} !== {F_HNDL, 4'b0000}) begin
      bad++; $display("FAIL single_handler: flags=%b ack=%b want %b 0000", flags(), bus.irq_ack, F_HNDL);
    end
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    total++;
    if ({flags(), bus.redirect_pc} !== {F_REST, 32'h40}) begin
      bad++; $display("FAIL single_restore: flags=%b rpc=%h want %b 00000040", flags(), bus.redirect_pc, F_REST);
    end
    tick();
    total++;
    if ({flags(), bus.epc, bus.int_cause} !== {F_IDLE, 32'h40, 2'd2}) begin
      bad++; $display("FAIL single_idle_hold: flags=%b epc=%h cause=%0d want %b 00000040 2",
                      flags(), bus.epc, bus.int_cause, F_IDLE);
    end
    bus.irq_in = '0;
    tick();
  endtask

  task automatic test_priority();
    bus.cur_pc = 32'h80;
    bus.irq_in = 4'b1010;
    tick(); tick();
    total++;
    if ({flags(), bus.irq_ack, bus.int_cause, bus.redirect_pc} !== {F_SAVE, 4'b0010, 2'd1, 32'h110}) begin
      bad++; $display("FAIL prio_first: flags=%b ack=%b cause=%0d rpc=%h want %b 0010 1 00000110",
                      flags(), bus.irq_ack, bus.int_cause, bus.redirect_pc, F_SAVE);
    end
    bus.cur_pc = 32'h84;
    tick();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    total++;
    if ({flags(), bus.redirect_pc} !== {F_REST, 32'h80}) begin
      bad++; $display("FAIL prio_restore: flags=%b rpc=%h want %b 00000080", flags(), bus.redirect_pc, F_REST);
    end
    tick();
    total++;
    if (flags() !== F_IDLE) begin
      bad++; $display("FAIL prio_idle_gap: flags=%b want %b", flags(), F_IDLE);
    end
    tick();
    total++;
    if ({flags(), bus.irq_ack, bus.int_cause, bus.redirect_pc, bus.epc}
        !== {F_SAVE, 4'b1000, 2'd3, 32'h130, 32'h84}) begin
      bad++; $display("FAIL prio_second: flags=%b ack=%b cause=%0d rpc=%h epc=%h want %b 1000 3 00000130 00000084",
                      flags(), bus.irq_ack, bus.int_cause, bus.redirect_pc, bus.epc, F_SAVE);
    end
    tick();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    bus.irq_in = '0;
    tick(); tick();
  endtask

  task automatic test_mask_stall();
    bus.irq_mask = 4'b0001;
    bus.irq_in   = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (flags() !== F_IDLE) begin
        bad++; $display("FAIL masked_no_save: cycle=%0d flags=%b want %b", i, flags(), F_IDLE);
      end
    end
    bus.pipe_stall = 1'b1;
    bus.irq_mask   = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (flags() !== F_IDLE) begin
        bad++; $display("FAIL stall_no_save: cycle=%0d flags=%b want %b", i, flags(), F_IDLE);
      end
    end
    bus.pipe_stall = 1'b0;
    tick();
    total++;
    if ({flags(), bus.int_cause, bus.redirect_pc} !== {F_SAVE, 2'd0, 32'h100}) begin
      bad++; $display("FAIL unstall_save: flags=%b cause=%0d rpc=%h want %b 0 00000100",
                      flags(), bus.int_cause, bus.redirect_pc, F_SAVE);
    end
    tick();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    bus.irq_in = '0;
    tick(); tick();
  endtask

  task automatic test_nesting();
    bus.irq_in = 4'b0010;
    tick(); tick();
    tick();
    bus.irq_in = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({flags(), bus.int_cause} !== {F_HNDL, 2'd1}) begin
        bad++; $display("FAIL nest_blocked: cycle=%0d flags=%b cause=%0d want %b 1",
                        i, flags(), bus.int_cause, F_HNDL);
      end
    end
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    total++;
    if (flags() !== F_REST) begin
      bad++; $display("FAIL nest_restore: flags=%b want %b", flags(), F_REST);
    end
    tick();
    tick();
    total++;
    if ({flags(), bus.int_cause, bus.irq_ack} !== {F_SAVE, 2'd0, 4'b0001}) begin
      bad++; $display("FAIL nest_deferred: flags=%b cause=%0d ack=%b want %b 0 0001",
                      flags(), bus.int_cause, bus.irq_ack, F_SAVE);
    end
    tick();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    bus.irq_in = '0;
    tick();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    total++;
    if (flags() !== F_IDLE) begin
      bad++; $display("FAIL eret_in_idle: flags=%b want %b", flags(), F_IDLE);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.cur_pc = 32'h200;
    bus.irq_in = 4'b0100;
    tick(); tick(); tick();
    bus.irq_in = 4'b1100;
    tick();
    reset = 1'b1;
    bus.irq_in = '0;
    tick();
    total++;
    if ({flags(), bus.irq_ack, bus.epc, bus.int_cause} !== '0) begin
      bad++; $display("FAIL reset_mid: flags=%b ack=%b epc=%h cause=%0d want all 0",
                      flags(), bus.irq_ack, bus.epc, bus.int_cause);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (flags() !== F_IDLE) begin
        bad++; $display("FAIL reset_pending_cleared: cycle=%0d flags=%b want %b", i, flags(), F_IDLE);
      end
    end
  endtask

  task automatic test_reset_release_high();
    reset = 1'b1;
    bus.irq_in = 4'b1000;
    tick();
    reset = 1'b0;
    tick();
    total++;
    if (flags() !== F_IDLE) begin
      bad++; $display("FAIL release_latch_wait: flags=%b want %b", flags(), F_IDLE);
    end
    tick();
    total++;
    if ({flags(), bus.int_cause} !== {F_SAVE, 2'd3}) begin
      bad++; $display("FAIL release_latch_save: flags=%b cause=%0d want %b 3", flags(), bus.int_cause, F_SAVE);
    end
    tick();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    bus.irq_in = '0;
    tick(); tick();
  endtask

  task automatic test_watchdog();
    bus.irq_in = 4'b0001;
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (flags() !== F_HNDL) begin
        bad++; $display("FAIL wdog_handler: cycle=%0d flags=%b want %b", i, flags(), F_HNDL);
      end
    end
    tick();
`ifdef PIPE_INT_WDOG_EN
    total++;
    if (flags() !== F_WDOG) begin
      bad++; $display("FAIL wdog_fire: flags=%b want %b", flags(), F_WDOG);
    end
    tick();
    total++;
    if (flags() !== F_IDLE) begin
      bad++; $display("FAIL wdog_after: flags=%b want %b", flags(), F_IDLE);
    end
`else
    for (int i = 0; i < 10; i++) begin
      total++;
      if (flags() !== F_HNDL) begin
        bad++; $display("FAIL no_wdog_hold: cycle=%0d flags=%b want %b", i, flags(), F_HNDL);
      end
      tick();
    end
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    tick();
`endif
    bus.irq_in = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask_stall();
    test_nesting();
    test_reset_mid();
    test_reset_release_high();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/pipe_int_ctrl.md
Name: pipe_int_ctrl

Overview:
Interrupt sequencer for the 5-stage pipeline. It edge-detects and prioritises external IRQ lines and drives INT_detected and INT_restore into the stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB), which snapshot and restore their contents. It also redirects the PC to the handler vector, captures EPC and cause, and returns the PC to EPC on eret.

Parameters:
N_IRQ, 4, number of interrupt source lines (1..16)
VEC_BASE, 32'h0000_0100, handler vector for cause 0
VEC_STRIDE, 32'h0000_0010, byte distance between consecutive cause vectors
WDOG_CYCLES, 1024, handler timeout; used only with PIPE_INT_WDOG_EN

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
irq_in  in  N_IRQ  raw level interrupt lines, synchronous to clk
irq_mask  in  N_IRQ  1 = source masked (latched but not taken)
glb_int_en  in  1  global interrupt enable
pipe_stall  in  1  pipeline frozen (load-use/memory); entry is deferred while 1
cur_pc  in  32  PC of the oldest non-committed instruction (resume address)
eret  in  1  return-from-interrupt retiring; meaningful only in HANDLER
INT_detected  out  1  snapshot strobe to all stage registers
INT_restore  out  1  restore strobe to all stage registers
pc_redirect  out  1  PC mux override valid
redirect_pc  out  32  target PC when pc_redirect=1
epc  out  32  saved resume PC
int_cause  out  clog2(N_IRQ) (min 1)  index of the taken source
int_active  out  1  high in SAVE and HANDLER
irq_ack  out  N_IRQ  one-hot, 1-cycle acknowledge of the taken source
wdog_fire  out  1  handler timeout pulse (tied 0 without the macro)

Behaviour:
- Reset: state=IDLE; pending, irq_q, epc, int_cause = 0; all outputs 0. A reset in any state aborts the sequence with no INT_restore. A line already high at reset release latches as pending on the next edge.
- Edge detect: irq_q <= irq_in; rise = irq_in & ~irq_q; pending <= (pending & ~ack_clr) | rise. Set wins when a bit sees a new rise in the same cycle it is cleared.
- Eligible = pending & ~irq_mask. Winner = lowest set index (fixed priority).
- States, all outputs registered/Moore:
  IDLE: if glb_int_en && |eligible && !pipe_stall, go to SAVE. Latch epc<=cur_pc and int_cause<=winner. Clear that pending bit.
  SAVE, exactly 1 cycle: INT_detected=1, irq_ack[int_cause]=1, pc_redirect=1, redirect_pc=VEC_BASE+int_cause*VEC_STRIDE (32-bit, wraps modulo 2^32). Next state is HANDLER.
  HANDLER: int_active=1. New edges latch as pending but are not taken (no nesting). eret=1 goes to RESTORE.
  RESTORE, 1 cycle: INT_restore=1, pc_redirect=1, redirect_pc=epc. Next state is IDLE.
- eret outside HANDLER is ignored. pipe_stall affects only IDLE exit.
- Latency: eligible edge to INT_detected is 2 cycles (edge reg, then IDLE decision). eret to INT_restore is 1 cycle.
- Back-to-back: RESTORE always passes through ≥1 IDLE cycle before the next SAVE. INT_detected and INT_restore are never high together.
- int_cause and epc hold their values until the next SAVE.

Optional Feature:
PIPE_INT_WDOG_EN.
- Defined: a counter clears on SAVE and increments in HANDLER. When it reaches WDOG_CYCLES-1 without eret, go to RESTORE and pulse wdog_fire for 1 cycle alongside INT_restore.
- Undefined: no counter, HANDLER waits indefinitely, wdog_fire=0.

Decomposition:
- Shared package pipe_int_pkg: state enum (IDLE, SAVE, HANDLER, RESTORE), VEC_BASE/VEC_STRIDE defaults, cause width function.
- One sub-module: irq_prio_enc (N_IRQ-wide lowest-index priority encoder with valid and index outputs).

Test Plan:
- Single IRQ: N_IRQ=4; after reset, raise irq_in[2] with mask=0, glb=1, cur_pc=0x40. Expect INT_detected, irq_ack=0100, redirect_pc=0x120 2 cycles later; epc=0x40, int_cause=2. Then eret gives INT_restore and redirect_pc=0x40 next cycle.
- Priority/pending: raise irq[3] and irq[1] in the same cycle. Expect cause 1 first. After eret and RESTORE, one IDLE cycle, then SAVE with cause 3 and redirect_pc=0x130.
- Masking/stall: irq[0] rises with mask[0]=1 → no SAVE. Clear the mask while pipe_stall=1 → no SAVE. Drop the stall → SAVE on the next cycle.
- Nesting blocked: in HANDLER, raise irq[0]. Expect no INT_detected until after RESTORE; then cause 0 is taken. eret pulsed while in IDLE → no INT_restore.
- Reset mid-HANDLER: assert reset. Expect IDLE, all outputs 0, pending cleared, no INT_restore pulse.
- Watchdog (PIPE_INT_WDOG_EN, WDOG_CYCLES=8): enter HANDLER with no eret. Expect RESTORE with wdog_fire=1 after 8 HANDLER cycles.
